ps2_direction_decoder: RTL

//  Receives PS/2 keyboard frames on KB_clk/data and decodes arrow-key make codes into the
//  2-bit snake heading (00 up, 01 left, 10 down, 11 right) consumed by the snake movement logic.

---
 rtl/ps2_direction_decoder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_direction_decoder.sv
// PS/2 receiver that turns arrow-key make codes into a 2-bit snake heading and refuses 180-degree turns.
// Optional build macro PS2_WASD_EN: un-extended W/A/S/D make codes steer as well.
module ps2_direction_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       master_clk,
  input  logic       rst_n,
  input  logic       KB_clk,
  input  logic       data,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic          kclk_s1_q, kclk_s2_q, data_s1_q, data_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe_s;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tocnt_q, tocnt_d;
  logic          byte_ok_s, err_s;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          cand_vld_s;
  logic [1:0]    cand_s;
  logic [1:0]    dir_q, dir_d;
  logic          dv_q, dv_d, fe_q, fe_d;
  logic [7:0]    key_q, key_d;

  // Glitch filter: filtered clock follows the synced clock only after FILTER_LEN differing samples in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (kclk_s2_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = kclk_s2_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end else begin
      fcnt_d = '0;
    end
  end

  assign strobe_s = filt_q & ~filt_d;

  // Frame FSM, stepped on the bit strobe, with a watchdog while a frame is in flight.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tocnt_d   = tocnt_q;
    byte_ok_s = 1'b0;
    err_s     = 1'b0;
    if (strobe_s) begin
      tocnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_s2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d  = {data_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_d   = data_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (data_s2_q && (^{shift_q, par_q})) begin
            byte_ok_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tocnt_q == TO_LAST) begin
        state_d = ST_IDLE;
        err_s   = 1'b1;
        tocnt_d = '0;
      end else begin
        tocnt_d = tocnt_q + 1'b1;
      end
    end else begin
      tocnt_d = '0;
    end
  end

  // Byte decode: prefix flags, candidate heading, and reversal/duplicate rejection.
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_d      = key_q;
    cand_vld_s = 1'b0;
    cand_s     = 2'b00;
    dir_d      = dir_q;
    dv_d       = 1'b0;
    fe_d       = err_s;
    if (byte_ok_s) begin
      key_d = shift_q;
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          cand_vld_s = 1'b0;
        end else if (ext_q) begin
          case (shift_q)
            8'h75:   begin cand_vld_s = 1'b1; cand_s = 2'b00; end
            8'h6B:   begin cand_vld_s = 1'b1; cand_s = 2'b01; end
            8'h72:   begin cand_vld_s = 1'b1; cand_s = 2'b10; end
            8'h74:   begin cand_vld_s = 1'b1; cand_s = 2'b11; end
            default: cand_vld_s = 1'b0;
          endcase
        end
`ifdef PS2_WASD_EN
        else begin
          case (shift_q)
            8'h1D:   begin cand_vld_s = 1'b1; cand_s = 2'b00; end
            8'h1C:   begin cand_vld_s = 1'b1; cand_s = 2'b01; end
            8'h1B:   begin cand_vld_s = 1'b1; cand_s = 2'b10; end
            8'h23:   begin cand_vld_s = 1'b1; cand_s = 2'b11; end
            default: cand_vld_s = 1'b0;
          endcase
        end
`else
        else begin
          cand_vld_s = 1'b0;
        end
`endif
      end
    end else begin
      key_d = key_q;
    end
    // Opposite headings differ only in bit 1, so xor == 10 marks a reversal.
    if (cand_vld_s && ((cand_s ^ dir_q) != 2'b10) && (cand_s != dir_q)) begin
      dir_d = cand_s;
      dv_d  = 1'b1;
    end else begin
      dir_d = dir_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge master_clk) begin
    if (!rst_n) begin
      kclk_s1_q <= 1'b1;
      kclk_s2_q <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      state_q   <= ST_IDLE;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tocnt_q   <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      dir_q     <= 2'b11;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      key_q     <= 8'h00;
    end else begin
      kclk_s1_q <= KB_clk;
      kclk_s2_q <= kclk_s1_q;
      data_s1_q <= data;
      data_s2_q <= data_s1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tocnt_q   <= tocnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      dir_q     <= dir_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      key_q     <= key_d;
    end
  end

  assign dir       = dir_q;
  assign dir_valid = dv_q;
  assign key_code  = key_q;
  assign frame_err = fe_q;

endmodule
